// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;

    // Highest legal response latency; also bounds the latency counter width.
    localparam int unsigned MAX_LATENCY = 15;
    localparam int unsigned CNT_W       = 4;

    // Request sequencing: accept in IDLE, count down in WAIT, pulse in RESP.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/mem_responder_array.sv
// Word-addressed 32-bit storage with a synchronous read port and a
// synchronous byte-lane write port. r_mem is left un-reset and may be
// preloaded hierarchically by a bench (u_array.r_mem[i]).
module mem_responder_array #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_wr_index,
    input  logic [31:0]           i_wr_data,
    input  logic [3:0]            i_wr_be,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_index,
    output logic [31:0]           o_rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Lane-masked write and registered read of the addressed word.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wr_be[i]) begin
                    r_mem[i_wr_index][8*i +: 8] <= i_wr_data[8*i +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_index];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle RV32I core: accepts one
// read/write request at a time and pulses o_mem_resp LATENCY cycles later.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_mem_address,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_byte_enable,
    output logic [31:0] o_mem_rdata,
    output logic        o_mem_resp,
    output logic        o_err
);

    if (LATENCY == 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
        $fatal(1, "mem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
    end

    if (ADDR_WIDTH == 0 || ADDR_WIDTH > 30) begin : g_bad_addr_width
        $fatal(1, "mem_responder: ADDR_WIDTH %0d outside 1..30", ADDR_WIDTH);
    end

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e                r_state;
    state_e                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;

    // Request captured at acceptance; inputs are ignored afterwards.
    logic [ADDR_WIDTH-1:0] r_index;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;
    logic                  r_is_write;
    logic                  r_oor;

    logic                  r_err;
    // Forces o_mem_rdata to zero after reset and after an out-of-range read.
    logic                  r_rd_zero;

    logic                  w_req;
    logic                  w_oor;
    logic [ADDR_WIDTH-1:0] w_index;
    logic                  w_accept;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_rd_index;
    logic                  w_rd_oor;
    logic                  w_we;
    logic [31:0]           w_arr_rdata;

    assign w_req   = i_mem_read | i_mem_write;
    assign w_index = i_mem_address[ADDR_WIDTH+1:2];
    assign w_oor   = |(i_mem_address >> (ADDR_WIDTH + 2));

    // Next-state, countdown and read-launch decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_rd_en      = 1'b0;
        w_rd_index   = r_index;
        w_rd_oor     = r_oor;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        // Straight to RESP: read uses the live request fields.
                        w_state_next = StResp;
                        w_rd_en      = ~i_mem_write;
                        w_rd_index   = w_index;
                        w_rd_oor     = w_oor;
                    end else begin
                        w_state_next = StWait;
                        w_cnt_next   = LAT_M1;
                    end
                end
            end
            StWait: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt <= 1) begin
                    w_state_next = StResp;
                    w_rd_en      = ~r_is_write;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Writes commit on the edge that ends RESP; reset discards them.
    assign w_we = (r_state == StResp) & r_is_write & ~r_oor & ~i_rst;

    // State register and latency counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the request fields at acceptance; both strobes high means write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_index    <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_oor      <= 1'b0;
        end else if (w_accept) begin
            r_index    <= w_index;
            r_wdata    <= i_mem_wdata;
            r_be       <= i_mem_byte_enable;
            r_is_write <= i_mem_write;
            r_oor      <= w_oor;
        end
    end

    // Sticky error flag and read-data zeroing control.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            if (w_accept && (w_oor || (i_mem_read && i_mem_write))) begin
                r_err <= 1'b1;
            end
            if (w_rd_en) begin
                r_rd_zero <= w_rd_oor;
            end
        end
    end

    mem_responder_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clk      (i_clk),
        .i_we       (w_we),
        .i_wr_index (r_index),
        .i_wr_data  (r_wdata),
        .i_wr_be    (r_be),
        .i_rd_en    (w_rd_en & ~i_rst),
        .i_rd_index (w_rd_index),
        .o_rd_data  (w_arr_rdata)
    );

    assign o_mem_resp  = (r_state == StResp);
    assign o_err       = r_err;
    assign o_mem_rdata = r_rd_zero ? 32'h0 : w_arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders (LATENCY 1, 2, 15) each driven by an
// independent core-like driver; a per-lane monitor checks every response.
module tb_mem_responder;

    localparam int unsigned AW    = 10;
    localparam int unsigned WORDS = 1 << AW;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    logic clk;
    int   cyc;
    int   checks;
    int   errors;
    bit   done [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int lane, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL lane%0d %s: got %h expected %h", lane, name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 2 : 15);

        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic        resp;
        logic        err;

        // Reference model: word storage, sticky error, last read value.
        logic [31:0] m_mem [int];
        bit          m_err;
        logic [31:0] m_last;
        exp_t        q [$];
        exp_t        mon_e;

        mem_responder #(
            .ADDR_WIDTH (AW),
            .LATENCY    (L)
        ) u_dut (
            .i_clk             (clk),
            .i_rst             (rst),
            .i_mem_read        (rd),
            .i_mem_write       (wr),
            .i_mem_address     (addr),
            .i_mem_wdata       (wdata),
            .i_mem_byte_enable (be),
            .o_mem_rdata       (rdata),
            .o_mem_resp        (resp),
            .o_err             (err)
        );

        always @(negedge clk) begin
            if (!rst && resp) begin
                if (q.size() == 0) begin
                    chk(g, "unexpected_resp", 32'(resp), 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk(g, "resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk(g, "err", 32'(err), 32'(mon_e.err));
                    chk(g, "rdata", rdata, mon_e.rdata);
                end
            end
        end

        task automatic issue(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b);
            exp_t        e;
            bit          oor;
            int          idx;
            bit          got;
            logic [31:0] word;
            oor   = (a / 4) >= WORDS;
            idx   = int'(a / 4);
            e.err = m_err | oor | (r & w);
            m_err = e.err;
            if (w) begin
                if (!oor) begin
                    word = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
                    for (int i = 0; i < 4; i++) begin
                        if (b[i]) word[8*i +: 8] = d[8*i +: 8];
                    end
                    m_mem[idx] = word;
                end
                e.rdata = m_last;
            end else begin
                e.rdata = oor ? 32'h0 : m_mem[idx];
                m_last  = e.rdata;
            end
            e.cyc = cyc + int'(L);
            q.push_back(e);
            rd = r; wr = w; addr = a; wdata = d; be = b;
            got = 1'b0;
            for (int k = 0; k < int'(L) + 4 && !got; k++) begin
                @(negedge clk);
                if (resp) begin
                    got = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    addr = $urandom; wdata = $urandom; be = 4'($urandom);
                end
            end
            if (!got) chk(g, "resp_timeout", 32'd0, 32'd1);
            @(posedge clk); #1;
            rd = 1'b0; wr = 1'b0; addr = $urandom; wdata = $urandom; be = 4'($urandom);
        endtask

        task automatic idle_gap();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        endtask

        task automatic check_reset_outputs(input string tag);
            @(negedge clk);
            chk(g, {tag, "_resp"}, 32'(resp), 32'd0);
            chk(g, {tag, "_err"}, 32'(err), 32'd0);
            chk(g, {tag, "_rdata"}, rdata, 32'h0);
            @(posedge clk); #1;
        endtask

        initial begin
            logic [31:0] pre;
            rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; be = '0;
            m_err = 1'b0; m_last = 32'h0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            check_reset_outputs("reset");

            // Fill a 16-word window; low address bits must be ignored.
            for (int i = 0; i < 16; i++) begin
                issue(1'b0, 1'b1, 32'(i * 4) + 32'($urandom_range(0, 3)), $urandom, 4'hF);
                idle_gap();
            end

            issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
            issue(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
            chk(g, "write_read", rdata, 32'hDEAD_BEEF);

            issue(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
            issue(1'b0, 1'b1, 32'h20, 32'h0000_00AA, 4'b0001);
            issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
            chk(g, "sb_lane", rdata, 32'h1122_33AA);
            issue(1'b0, 1'b1, 32'h20, 32'h0000_5566, 4'b0011);
            issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
            issue(1'b0, 1'b1, 32'h20, $urandom, 4'b0000);
            issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
            chk(g, "be_zero", rdata, 32'h1122_5566);

            issue(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
            chk(g, "oor_rdata", rdata, 32'h0);
            chk(g, "oor_err", 32'(err), 32'd1);
            issue(1'b0, 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF);
            issue(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
            issue(1'b1, 1'b1, 32'h30, 32'h0BAD_CAFE, 4'hF);
            issue(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
            chk(g, "rw_as_write", rdata, 32'h0BAD_CAFE);

            for (int n = 0; n < 40; n++) begin
                int unsigned p;
                logic [31:0] a;
                p = $urandom_range(0, 99);
                a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
                if (p % 10 == 3) a = a | (32'h1 << $urandom_range(12, 31));
                if (p < 45)      issue(1'b0, 1'b1, a, $urandom, 4'($urandom));
                else if (p < 90) issue(1'b1, 1'b0, a, $urandom, 4'($urandom));
                else             issue(1'b1, 1'b1, a, $urandom, 4'($urandom));
                idle_gap();
            end

            // Reset lands mid-request (WAIT, or the accept cycle when LATENCY is 1).
            pre   = m_mem[8];
            rd    = 1'b0; wr = 1'b1; addr = 32'h20; wdata = ~pre; be = 4'hF;
            rst   = (L == 1);
            @(posedge clk); #1;
            rst   = 1'b1;
            @(posedge clk); #1;
            rst   = 1'b0; wr = 1'b0;
            m_err = 1'b0; m_last = 32'h0;
            check_reset_outputs("midop_reset");
            issue(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
            chk(g, "write_discarded", rdata, pre);

            repeat (20) @(posedge clk);
            chk(g, "queue_drain", 32'(q.size()), 32'd0);
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && !(done[0] && done[1] && done[2]); i++) @(posedge clk);
        if (!(done[0] && done[1] && done[2])) begin
            checks++;
            errors++;
            $display("FAIL global_timeout: lanes done %0d%0d%0d expected 111",
                     done[0], done[1], done[2]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
